// File: rtl/example_block_in_fifo_if.sv
// Valid/ready handshake bundle between the upstream source, the input FIFO
// and example_block_top. master = environment side, slave = FIFO side.
interface example_block_in_fifo_if #(
    parameter int DAT_W = 32
);
    logic             in_vld;
    logic [DAT_W-1:0] in_dat;
    logic             in_rdy;
    logic             out_vld;
    logic [DAT_W-1:0] out_dat;
    logic             out_rdy;

    modport master (
        output in_vld, in_dat, out_rdy,
        input  in_rdy, out_vld, out_dat
    );

    modport slave (
        input  in_vld, in_dat, out_rdy,
        output in_rdy, out_vld, out_dat
    );
endinterface

// File: rtl/example_block_in_fifo.sv
// Input buffer for example_block_top: first-word-fall-through FIFO with
// occupancy, almost-full, high-water mark and synchronous flush.
module example_block_in_fifo #(
    parameter int DAT_W    = 32,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6,
    localparam int CNT_W   = $clog2(DEPTH) + 1,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    example_block_in_fifo_if.slave bus,
    input  logic                 flush,
    input  logic                 clr_hwm,
    output logic [CNT_W-1:0]     count,
    output logic                 afull,
    output logic [CNT_W-1:0]     hwm
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PART  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [DAT_W-1:0] mem [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] hwm_q, hwm_d;
    logic             afull_q, afull_d;

    logic in_rdy;
    logic out_vld;
    logic push;
    logic pop;

    // Handshake flags come from registered state only.
    always_comb begin
        in_rdy  = (state_q == ST_EMPTY) || (state_q == ST_PART);
        out_vld = (state_q == ST_PART)  || (state_q == ST_FULL);
        push    = bus.in_vld & in_rdy;
        pop     = out_vld & bus.out_rdy;
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_vld = out_vld;
    assign bus.out_dat = mem[rd_ptr_q];
    assign count       = count_q;
    assign afull       = afull_q;
    assign hwm         = hwm_q;

    // Next-state: FSM, pointers, occupancy and status; flush overrides push/pop.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            state_d  = ST_FLUSH;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_PART;
                ST_PART: begin
                    if (push && !pop && count_q == CNT_W'(DEPTH - 1))
                        state_d = ST_FULL;
                    else if (pop && !push && count_q == CNT_W'(1))
                        state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_PART;
                ST_FLUSH: state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end

        hwm_d   = clr_hwm ? count_d : ((count_d > hwm_q) ? count_d : hwm_q);
        afull_d = (count_d >= CNT_W'(AFULL_TH));
    end

    // Control/status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            afull_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            afull_q  <= afull_d;
        end
    end

    // Storage array, not reset; a push in a flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= bus.in_dat;
    end
endmodule

// File: tb/tb_example_block_in_fifo.sv
// Bench for example_block_in_fifo: queue-based reference model plus a
// scoreboard of expected output words checked by an independent monitor.
module tb_example_block_in_fifo;
    localparam int DAT_W    = 32;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             clr_hwm;
    logic [CNT_W-1:0] count;
    logic             afull;
    logic [CNT_W-1:0] hwm;

    example_block_in_fifo_if #(.DAT_W(DAT_W)) bus ();

    example_block_in_fifo #(
        .DAT_W    (DAT_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .flush   (flush),
        .clr_hwm (clr_hwm),
        .count   (count),
        .afull   (afull),
        .hwm     (hwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 0;

    // Reference model: contents as a queue, a flushing flag and the high-water mark.
    logic [DAT_W-1:0] m_q[$];
    bit               m_flushing = 0;
    int               m_hwm = 0;
    // Scoreboard of words still expected at the output.
    logic [DAT_W-1:0] sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge from the inputs that were applied.
    always @(posedge clk) begin
        bit rdy, vld;
        rdy = !m_flushing && (m_q.size() < DEPTH);
        vld = !m_flushing && (m_q.size() > 0);
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_flushing = 0;
            m_hwm = 0;
        end else if (flush) begin
            m_q.delete();
            sb_q.delete();
            m_flushing = 1;
            m_hwm = clr_hwm ? 0 : m_hwm;
        end else begin
            m_flushing = 0;
            if (vld && bus.out_rdy) void'(m_q.pop_front());
            if (rdy && bus.in_vld) begin
                m_q.push_back(bus.in_dat);
                sb_q.push_back(bus.in_dat);
            end
            if (clr_hwm) m_hwm = m_q.size();
            else if (m_q.size() > m_hwm) m_hwm = m_q.size();
        end
    end

    // Monitor: status against the model, consumed words against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("in_rdy",  64'(bus.in_rdy),  64'(!m_flushing && m_q.size() < DEPTH));
                chk("out_vld", 64'(bus.out_vld), 64'(!m_flushing && m_q.size() > 0));
                chk("count",   64'(count),       64'(m_q.size()));
                chk("afull",   64'(afull),       64'(m_q.size() >= AFULL_TH));
                chk("hwm",     64'(hwm),         64'(m_hwm));
                if (bus.out_vld && bus.out_rdy && !flush && !rst) begin
                    if (sb_q.size() == 0) begin
                        chk("pop_unexpected", 64'(bus.out_dat), 64'hDEAD_0000_0000_0000);
                    end else begin
                        chk("out_dat", 64'(bus.out_dat), 64'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic step(input bit v, input logic [DAT_W-1:0] d, input bit ordy,
                        input bit fl, input bit clr, input bit r);
        bus.in_vld  = v;
        bus.in_dat  = d;
        bus.out_rdy = ordy;
        flush       = fl;
        clr_hwm     = clr;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(0, '0, ordy, 0, 0, 0);
    endtask

    initial begin
        bus.in_vld = 0; bus.in_dat = '0; bus.out_rdy = 0;
        flush = 0; clr_hwm = 0; rst = 1;
        @(posedge clk); #1;
        step(0, '0, 0, 0, 0, 1);
        armed = 1;

        // Fill to full with the consumer stalled, then one extra offered word.
        for (int i = 0; i < 9; i++) step(1, 32'h11 + 32'(i), 0, 0, 0, 0);
        idle(1, 0);
        chk("full_hwm", 64'(hwm), 64'(DEPTH));

        // Drain in order.
        idle(9, 1);

        // Steady state at four entries with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i), 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 32'h200 + 32'(i), 1, 0, 0, 0);
        idle(5, 1);

        // Push into empty with consumer ready in the same cycle.
        step(1, 32'hA5, 1, 0, 0, 0);
        idle(2, 1);

        // Flush at five entries with push and pop offered; hwm held, then cleared.
        step(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i), 0, 0, 0, 0);
        step(1, 32'h3FF, 1, 1, 0, 0);
        idle(2, 0);
        chk("hwm_after_flush", 64'(hwm), 64'd5);
        step(0, '0, 0, 0, 1, 0);
        idle(1, 0);

        // Reset with seven entries and a push in flight.
        for (int i = 0; i < 7; i++) step(1, 32'h400 + 32'(i), 0, 0, 0, 0);
        step(1, 32'h4FF, 1, 0, 0, 1);
        idle(1, 0);

        // Random traffic with occasional flush, hwm clear and reset.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        idle(12, 1);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
